// File: rtl/nibble_serializer_pkg.sv
// Shared definitions for the nibble serializer: datapath widths, FSM state
// encoding and the held-byte payload.
package nibble_serializer_pkg;

    localparam int unsigned NIBBLE_W = 4;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned CNT_W    = 8;

    // Serializer phase: nothing held, first nibble presented, second nibble presented.
    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2
    } ser_state_t;

    // Byte captured on an input transfer.
    typedef struct packed {
        logic              last;
        logic [BYTE_W-1:0] data;
    } byte_beat_t;

endpackage

// File: rtl/mux_nibble.sv
// Selects one nibble of a byte.
//   byte_in  : byte to split
//   sel_hi   : 1 selects bits [7:4], 0 selects bits [3:0]
//   nibble_c : selected nibble (combinational)
module mux_nibble
    import nibble_serializer_pkg::*;
(
    input  logic [BYTE_W-1:0]   byte_in,
    input  logic                sel_hi,
    output logic [NIBBLE_W-1:0] nibble_c
);

    assign nibble_c = sel_hi ? byte_in[BYTE_W-1:NIBBLE_W] : byte_in[NIBBLE_W-1:0];

endmodule

// File: rtl/nibble_serializer.sv
// Byte-to-nibble serializer with ready/valid on both sides.
//   inClk, inResetn : clock, async active-low reset
//   inData, inValid, inLast, inReady   : byte input handshake
//   outData, outValid, outLast, outReady : nibble output handshake
//   outSymCnt : nibbles transferred in the current frame, saturating
// LSN_FIRST = 1 emits bits [3:0] before [7:4]; 0 emits [7:4] first.
module nibble_serializer
    import nibble_serializer_pkg::*;
#(
    parameter bit LSN_FIRST = 1'b1
) (
    input  logic                inClk,
    input  logic                inResetn,
    input  logic [BYTE_W-1:0]   inData,
    input  logic                inValid,
    input  logic                inLast,
    input  logic                outReady,
    output logic                inReady,
    output logic [NIBBLE_W-1:0] outData,
    output logic                outValid,
    output logic                outLast,
    output logic [CNT_W-1:0]    outSymCnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ser_state_t state_q;
    ser_state_t state_d;

    byte_beat_t byte_q;
    byte_beat_t byte_d_c;

    logic                byte_xfer_c;
    logic                nib_xfer_c;
    logic                sel_hi_c;
    logic [NIBBLE_W-1:0] nibble_c;

    logic                clr_pend_q;
    logic [CNT_W-1:0]    cnt_base_c;
    logic [CNT_W-1:0]    cnt_d_c;

    // State register.
    always_ff @(posedge inClk or negedge inResetn) begin
        if (!inResetn) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and input-side ready.
    always_comb begin
        state_d = state_q;
        inReady = 1'b0;
        case (state_q)
            EMPTY: begin
                inReady = 1'b1;
                if (inValid) begin
                    state_d = FIRST;
                end
            end
            FIRST: begin
                if (outReady) begin
                    state_d = SECOND;
                end
            end
            SECOND: begin
                // A new byte can only land while the second nibble leaves.
                inReady = outReady;
                if (outReady) begin
                    state_d = inValid ? FIRST : EMPTY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    assign byte_xfer_c = inValid && inReady;
    assign nib_xfer_c  = outValid && outReady;

    // Outputs are precomputed from the byte that will be held next cycle.
    assign byte_d_c = byte_xfer_c ? byte_beat_t'{last: inLast, data: inData} : byte_q;
    assign sel_hi_c = (state_d == SECOND) ? LSN_FIRST : !LSN_FIRST;

    mux_nibble u_mux_nibble (
        .byte_in  (byte_d_c.data),
        .sel_hi   (sel_hi_c),
        .nibble_c (nibble_c)
    );

    // Held byte and registered output symbol.
    always_ff @(posedge inClk or negedge inResetn) begin
        if (!inResetn) begin
            byte_q   <= '0;
            outValid <= 1'b0;
            outLast  <= 1'b0;
            outData  <= '0;
        end else begin
            if (byte_xfer_c) begin
                byte_q <= byte_d_c;
            end
            outValid <= (state_d != EMPTY);
            outLast  <= (state_d == SECOND) && byte_d_c.last;
            if (state_d != EMPTY) begin
                outData <= nibble_c;
            end
        end
    end

    // Frame symbol count; a pending clear from the previous frame's last
    // nibble is applied before this cycle's increment.
    always_comb begin
        cnt_base_c = clr_pend_q ? '0 : outSymCnt;
        cnt_d_c    = cnt_base_c;
        if (nib_xfer_c && (cnt_base_c != CNT_MAX)) begin
            cnt_d_c = cnt_base_c + CNT_W'(1);
        end
    end

    always_ff @(posedge inClk or negedge inResetn) begin
        if (!inResetn) begin
            outSymCnt  <= '0;
            clr_pend_q <= 1'b0;
        end else begin
            outSymCnt  <= cnt_d_c;
            clr_pend_q <= nib_xfer_c && outLast;
        end
    end

endmodule

// File: tb/tb_nibble_serializer.sv
// Bench for nibble_serializer: both nibble orders run side by side on the
// same stimulus and are compared every cycle against a queue-based model.
module tb_nibble_serializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_last;
    logic       out_ready;

    logic       in_ready0, out_valid0, out_last0;
    logic [3:0] out_data0;
    logic [7:0] cnt0;
    logic       in_ready1, out_valid1, out_last1;
    logic [3:0] out_data1;
    logic [7:0] cnt1;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0] b;
        bit         second;
        bit         last;
    } ent_t;

    ent_t       exp_q[$];
    logic [3:0] log_nib[$];
    bit         log_last[$];
    int         log_cyc[$];
    int         cnt_m    = 0;
    bit         pend_clr = 0;
    logic [15:0] rdy_pat;

    always #5 clk = ~clk;

    nibble_serializer #(.LSN_FIRST(1'b1)) dut_lsn (
        .inClk(clk), .inResetn(rst_n), .inData(in_data), .inValid(in_valid),
        .inLast(in_last), .outReady(out_ready), .inReady(in_ready0),
        .outData(out_data0), .outValid(out_valid0), .outLast(out_last0),
        .outSymCnt(cnt0)
    );

    nibble_serializer #(.LSN_FIRST(1'b0)) dut_msn (
        .inClk(clk), .inResetn(rst_n), .inData(in_data), .inValid(in_valid),
        .inLast(in_last), .outReady(out_ready), .inReady(in_ready1),
        .outData(out_data1), .outValid(out_valid1), .outLast(out_last1),
        .outSymCnt(cnt1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: each accepted byte yields two queued symbols; the head symbol
    // is what must be on the output, and the count follows the frame rules.
    always @(negedge clk) begin
        ent_t       h;
        bit         have;
        bit         nib;
        bit         rdy_m;
        int         base;
        logic [3:0] lo, hi;
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            cnt_m    = 0;
            pend_clr = 0;
            check("rst_valid", out_valid0, 0);
            check("rst_last",  out_last0,  0);
            check("rst_data",  out_data0,  0);
            check("rst_cnt",   cnt0,       0);
            check("rst_data_msn", out_data1, 0);
        end else begin
            have = (exp_q.size() != 0);
            check("valid",     out_valid0, have);
            check("valid_msn", out_valid1, have);
            if (have) begin
                h  = exp_q[0];
                lo = h.b[3:0];
                hi = h.b[7:4];
                check("data",     out_data0, h.second ? hi : lo);
                check("data_msn", out_data1, h.second ? lo : hi);
                check("last",     out_last0, h.second && h.last);
                check("last_msn", out_last1, h.second && h.last);
                rdy_m = h.second ? out_ready : 1'b0;
            end else begin
                rdy_m = 1'b1;
            end
            check("in_ready",     in_ready0, rdy_m);
            check("in_ready_msn", in_ready1, rdy_m);
            check("sym_cnt",      cnt0, cnt_m);
            check("sym_cnt_msn",  cnt1, cnt_m);

            nib  = have && out_ready;
            base = pend_clr ? 0 : cnt_m;
            cnt_m = nib ? ((base == 255) ? 255 : base + 1) : base;
            pend_clr = nib && h.second && h.last;
            if (nib) begin
                log_nib.push_back(out_data0);
                log_last.push_back(out_last0);
                log_cyc.push_back(cyc);
                void'(exp_q.pop_front());
            end
            if (in_valid && rdy_m) begin
                exp_q.push_back('{b: in_data, second: 1'b0, last: 1'b0});
                exp_q.push_back('{b: in_data, second: 1'b1, last: in_last});
            end
        end
    end

    // Offer one byte until accepted; inputs change only just after posedge.
    task automatic send_byte(input logic [7:0] b, input logic l);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        in_last  = l;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        in_last  = 1'($urandom);
        if (!ok) check("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int         start;
        logic [3:0] exp_s [6];
        exp_s = '{4'h2, 4'h1, 4'h4, 4'h3, 4'h6, 4'h5};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b1;
        idle(2);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready0, 1);
        idle(1);

        // Single byte 0xA5, last.
        send_byte(8'hA5, 1'b1);
        @(negedge clk);
        check("a5_nib0", out_data0, 4'h5);
        check("a5_last0", out_last0, 0);
        check("a5_cnt0", cnt0, 0);
        @(negedge clk);
        check("a5_nib1", out_data0, 4'hA);
        check("a5_last1", out_last0, 1);
        check("a5_cnt1", cnt0, 1);
        @(negedge clk);
        check("a5_cnt_after", cnt0, 2);
        check("a5_idle_valid", out_valid0, 0);
        @(negedge clk);
        check("a5_cnt_clear", cnt0, 0);
        idle(2);

        // Back-to-back stream: one nibble per cycle.
        start = log_nib.size();
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h56, 1'b1);
        idle(4);
        check("stream_len", log_nib.size() - start, 6);
        if (log_nib.size() - start == 6) begin
            for (int i = 0; i < 6; i++) begin
                check("stream_nib", log_nib[start+i], exp_s[i]);
                check("stream_gap", log_cyc[start+i], log_cyc[start] + i);
            end
            check("stream_last", log_last[start+5], 1);
        end

        // Stall with first nibble presented.
        out_ready = 1'b0;
        start = log_nib.size();
        send_byte(8'hC3, 1'b1);
        repeat (5) begin
            @(negedge clk);
            check("stall_data", out_data0, 4'h3);
            check("stall_data_msn", out_data1, 4'hC);
            check("stall_in_ready", in_ready0, 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        idle(4);
        check("stall_len", log_nib.size() - start, 2);
        if (log_nib.size() - start == 2) begin
            check("stall_nib0", log_nib[start], 4'h3);
            check("stall_nib1", log_nib[start+1], 4'hC);
        end

        // Irregular downstream readiness.
        rdy_pat = 16'b1011_0011_1001_0110;
        fork
            begin
                send_byte(8'h3C, 1'b0);
                send_byte(8'h81, 1'b0);
                send_byte(8'hF0, 1'b1);
            end
            begin
                for (int i = 0; i < 16; i++) begin
                    out_ready = rdy_pat[i];
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        idle(6);

        // Long frame: count saturates, then clears.
        for (int i = 0; i < 300; i++) begin
            send_byte(8'(i), (i == 299));
        end
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("sat_cnt", cnt0, 255);
        @(negedge clk);
        check("sat_clear", cnt0, 0);
        idle(2);

        // Reset while the second nibble is presented.
        send_byte(8'h99, 1'b0);
        idle(1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", out_valid0, 0);
        check("rst_mid_valid_msn", out_valid1, 0);
        idle(1);
        rst_n = 1'b1;
        @(negedge clk);
        check("rel_in_ready", in_ready0, 1);
        idle(1);
        send_byte(8'h7E, 1'b1);
        @(negedge clk);
        check("7e_nib0", out_data0, 4'hE);
        check("7e_cnt0", cnt0, 0);
        @(negedge clk);
        check("7e_nib1", out_data0, 4'h7);
        check("7e_cnt1", cnt0, 1);
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
